// File: rtl/sha256_job_scheduler.sv
// sha256_job_scheduler: round-robin arbiter that feeds hash jobs from NUM_REQ requesters
// to a single SHA-256 core and reports completion, or a watchdog timeout if the core hangs.
module sha256_job_scheduler #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]  i_req_input_addr,
    input  logic [NUM_REQ*ADDR_W-1:0]  i_req_hash_addr,
    output logic [NUM_REQ-1:0]         o_req_ready,
    output logic [NUM_REQ-1:0]         o_cmp_valid,
    output logic                       o_cmp_err,
    output logic                       o_core_start,
    output logic [ADDR_W-1:0]          o_core_input_addr,
    output logic [ADDR_W-1:0]          o_core_hash_addr,
    input  logic                       i_core_done,
    output logic                       o_busy,
    output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);
    localparam int unsigned ID_W   = $clog2(NUM_REQ);
    localparam int unsigned WDOG_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StGrant,
        StStart,
        StWaitLow,
        StWaitDone,
        StComplete,
        StTimeout,
        StDrain
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ID_W-1:0]     r_rr_ptr;
    logic [ID_W-1:0]     r_grant_id;
    logic [WDOG_W-1:0]   r_wdog;
    logic [NUM_REQ-1:0]  r_req_ready;
    logic [NUM_REQ-1:0]  r_cmp_valid;
    logic                r_cmp_err;
    logic                r_core_start;
    logic [ADDR_W-1:0]   r_core_input_addr;
    logic [ADDR_W-1:0]   r_core_hash_addr;
    logic                r_busy;

    logic                w_sel_found;
    logic [ID_W-1:0]     w_sel_idx;
    int unsigned         w_scan_idx;
    logic [NUM_REQ-1:0]  w_sel_onehot;
    logic [NUM_REQ-1:0]  w_grant_onehot;
    logic                w_wdog_expired;

    assign w_sel_onehot   = NUM_REQ'(1) << w_sel_idx;
    assign w_grant_onehot = NUM_REQ'(1) << r_grant_id;
    assign w_wdog_expired = (r_wdog == WDOG_LAST);

    // Round-robin pick: first valid requester scanning upward from the one after rr_ptr.
    always_comb begin
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        w_scan_idx  = 0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_scan_idx = (32'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_sel_found && i_req_valid[ID_W'(w_scan_idx)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = ID_W'(w_scan_idx);
            end
        end
    end

    // Next-state logic; on a coincident exit and timeout the exit condition wins.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:     if (|i_req_valid && i_core_done) w_state_next = StGrant;
            StGrant:    w_state_next = w_sel_found ? StStart : StIdle;
            StStart:    w_state_next = StWaitLow;
            StWaitLow: begin
                if (!i_core_done)        w_state_next = StWaitDone;
                else if (w_wdog_expired) w_state_next = StTimeout;
            end
            StWaitDone: begin
                if (i_core_done)         w_state_next = StComplete;
                else if (w_wdog_expired) w_state_next = StTimeout;
            end
            StComplete: w_state_next = StIdle;
            StTimeout:  w_state_next = StDrain;
            StDrain:    if (i_core_done) w_state_next = StIdle;
            default:    w_state_next = StIdle;
        endcase
    end

    // State, watchdog, arbitration pointer and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= StIdle;
            r_rr_ptr          <= ID_W'(NUM_REQ - 1);
            r_grant_id        <= '0;
            r_wdog            <= '0;
            r_req_ready       <= '0;
            r_cmp_valid       <= '0;
            r_cmp_err         <= 1'b0;
            r_core_start      <= 1'b0;
            r_core_input_addr <= '0;
            r_core_hash_addr  <= '0;
            r_busy            <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_busy       <= (w_state_next != StIdle);
            r_req_ready  <= '0;
            r_cmp_valid  <= '0;
            r_cmp_err    <= 1'b0;
            r_core_start <= 1'b0;

            if (r_state == StGrant && w_sel_found) begin
                r_req_ready       <= w_sel_onehot;
                r_grant_id        <= w_sel_idx;
                r_core_input_addr <= i_req_input_addr[w_sel_idx*ADDR_W +: ADDR_W];
                r_core_hash_addr  <= i_req_hash_addr[w_sel_idx*ADDR_W +: ADDR_W];
            end

            if (r_state == StStart) begin
                r_core_start <= 1'b1;
                r_wdog       <= '0;
            end else if (r_state == StWaitLow || r_state == StWaitDone) begin
                if (r_wdog != '1) r_wdog <= r_wdog + 1'b1;
            end

            // cmp is raised on entry so it is visible the cycle after core_done rises.
            if (w_state_next == StComplete) begin
                r_cmp_valid <= w_grant_onehot;
            end else if (w_state_next == StTimeout) begin
                r_cmp_valid <= w_grant_onehot;
                r_cmp_err   <= 1'b1;
            end

            if (r_state == StComplete || r_state == StTimeout) r_rr_ptr <= r_grant_id;
        end
    end

    assign o_req_ready       = r_req_ready;
    assign o_cmp_valid       = r_cmp_valid;
    assign o_cmp_err         = r_cmp_err;
    assign o_core_start      = r_core_start;
    assign o_core_input_addr = r_core_input_addr;
    assign o_core_hash_addr  = r_core_hash_addr;
    assign o_busy            = r_busy;
    assign o_grant_id        = r_grant_id;

endmodule
